ikaopll_timinggen: RTL

- Master timing generator and slot scheduler for the OPLL operator pipeline.
- Derives the phi1 positive- and negative-edge clock enables from the phiM enable.
- Runs the 18-slot operator cycle counter.
- Decodes the per-slot select strobes (cycle markers, modulator/carrier, rhythm HH/TT, channel/operator index) consumed by the EG, PG and OP blocks.
- Every downstream block is sequenced from this one.

---
 rtl/ikaopll_pkg.sv | 31 +++
 rtl/ikaopll_phi1_div.sv | 46 ++++
 rtl/ikaopll_timinggen.sv | 100 ++++++++++
 3 files changed

// File: rtl/ikaopll_pkg.sv
// Shared definitions for the OPLL timing generator: slot constants, slot
// type and the slot-to-channel/operator mapping used by the decode.
package ikaopll_pkg;

   localparam int NSLOT_DEF = 18;
   localparam int SLOT_HH   = 13;
   localparam int SLOT_TT   = 14;

   typedef logic [4:0] slot_t;
   typedef logic [3:0] ch_t;

   typedef struct packed {
      ch_t  ch;
      logic is_mod;
   } chop_t;

   // Slots run in groups of six: three modulators then the three matching carriers.
   function automatic chop_t slot_to_chop(input slot_t slot);
      chop_t r;
      slot_t grp;
      slot_t pos;
      slot_t op;
      grp      = slot / slot_t'(6);
      pos      = slot - grp * slot_t'(6);
      r.is_mod = (pos < slot_t'(3));
      op       = r.is_mod ? pos : pos - slot_t'(3);
      r.ch     = ch_t'(grp * slot_t'(3) + op);
      return r;
   endfunction

endpackage

// File: rtl/ikaopll_phi1_div.sv
// Phi1 phase divider: turns phiM enables into the phi1 positive/negative
// edge enable pair, one i_EMUCLK wide each, never coincident.
module ikaopll_phi1_div #(
   parameter int PHI1_DIV = 2
) (
   input  logic i_EMUCLK,
   input  logic i_IC_n,
   input  logic i_phiM_PCEN_n,
   output logic o_phi1_PCEN_n,
   output logic o_phi1_NCEN_n
);

   if (PHI1_DIV != 1 && PHI1_DIV != 2) begin : g_bad_div
      $error("ikaopll_phi1_div: PHI1_DIV must be 1 or 2");
   end

   localparam logic [1:0] PH_LAST = 2'(2 * PHI1_DIV - 1);
   localparam logic [1:0] PH_NEG  = 2'(PHI1_DIV);

   logic [1:0] ph_q;
   logic [1:0] ph_d;
   logic       phim_en;

   // NOTE: next-state logic uses blocking '=' with a default on every path so no latch is inferred.
   always_comb begin
      phim_en = ~i_phiM_PCEN_n;
      ph_d    = ph_q;
      if (phim_en) begin
         ph_d = (ph_q == PH_LAST) ? 2'd0 : ph_q + 2'd1;
      end
   end

   // NOTE: state registers take non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge i_EMUCLK) begin
      if (!i_IC_n) begin
         ph_q <= 2'd0;
      end else begin
         ph_q <= ph_d;
      end
   end

   // Enables are held off while the chip is in reset.
   assign o_phi1_PCEN_n = ~(i_IC_n & phim_en & (ph_q == 2'd0));
   assign o_phi1_NCEN_n = ~(i_IC_n & phim_en & (ph_q == PH_NEG));

endmodule

// File: rtl/ikaopll_timinggen.sv
// OPLL master timing generator: phi1 enables, 18-slot operator counter and
// per-slot select decode. Optional sample counter: IKAOPLL_SAMPLE_CNTR_EN.
module ikaopll_timinggen
   import ikaopll_pkg::*;
#(
   parameter int NSLOT    = NSLOT_DEF,
   parameter int PHI1_DIV = 2
) (
   input  logic        i_EMUCLK,
   input  logic        i_IC_n,
   input  logic        i_phiM_PCEN_n,
   input  logic        i_RHYTHM,
   input  logic        i_TEST_FREEZE,
   output logic        o_phi1_PCEN_n,
   output logic        o_phi1_NCEN_n,
   output logic        o_CYCLE_00,
   output logic        o_CYCLE_17,
   output logic        o_MnC_SEL,
   output logic        o_HH_TT_SEL,
   output logic [3:0]  o_CH,
`ifdef IKAOPLL_SAMPLE_CNTR_EN
   output logic [15:0] o_SAMPLE_CNT,
`endif
   output logic [4:0]  o_SLOT
);

   if (NSLOT < 2 || NSLOT > 32) begin : g_bad_nslot
      $error("ikaopll_timinggen: NSLOT must fit the 5-bit slot counter");
   end

   localparam slot_t SLOT_LAST = slot_t'(NSLOT - 1);

   logic  ncen_n;
   slot_t slot_q;
   slot_t slot_d;
   logic  slot_adv;
   logic  slot_wrap;
   chop_t chop;

   ikaopll_phi1_div #(
      .PHI1_DIV      (PHI1_DIV)
   ) u_phi1_div (
      .i_EMUCLK      (i_EMUCLK),
      .i_IC_n        (i_IC_n),
      .i_phiM_PCEN_n (i_phiM_PCEN_n),
      .o_phi1_PCEN_n (o_phi1_PCEN_n),
      .o_phi1_NCEN_n (ncen_n)
   );

   assign o_phi1_NCEN_n = ncen_n;

   // Freeze only stalls the slot counter; the phi1 enables keep running.
   always_comb begin
      slot_adv  = ~ncen_n & ~i_TEST_FREEZE;
      slot_wrap = slot_adv & (slot_q == SLOT_LAST);
      slot_d    = slot_q;
      if (slot_adv) begin
         slot_d = slot_wrap ? slot_t'(0) : slot_q + slot_t'(1);
      end
   end

   always_ff @(posedge i_EMUCLK) begin
      if (!i_IC_n) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign chop        = slot_to_chop(slot_q);
   assign o_SLOT      = slot_q;
   assign o_CYCLE_00  = (slot_q == slot_t'(0));
   assign o_CYCLE_17  = (slot_q == SLOT_LAST);
   assign o_MnC_SEL   = chop.is_mod;
   assign o_CH        = chop.ch;
   assign o_HH_TT_SEL = i_RHYTHM & ((slot_q == slot_t'(SLOT_HH)) | (slot_q == slot_t'(SLOT_TT)));

`ifdef IKAOPLL_SAMPLE_CNTR_EN
   logic [15:0] scnt_q;
   logic [15:0] scnt_d;

   always_comb begin
      scnt_d = scnt_q;
      if (slot_wrap) begin
         scnt_d = scnt_q + 16'd1;
      end
   end

   always_ff @(posedge i_EMUCLK) begin
      if (!i_IC_n) begin
         scnt_q <= '0;
      end else begin
         scnt_q <= scnt_d;
      end
   end

   assign o_SAMPLE_CNT = scnt_q;
`endif

endmodule
